// File: rtl/ctrl_hazard_pipe.sv
// Pipelined control bundle for the 5-stage MIPS core: carries decode control through E/M/W
// and derives forwarding selects, load-use / branch-operand stalls and D/E flushes.
// Latency: D->E 1 cycle, D->M 2, D->W 3; forward/stall/flush outputs are combinational.
// Backpressure: i_MemStall freezes E/M/W and holds F/D; a hazard stall holds F/D and bubbles E.
//
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_*D                          decode-stage control and register specifiers
//   i_MemStall                    data memory not ready, freeze everything
//   o_*E / o_*M / o_*W            registered stage control and resolved destinations
//   o_ForwardAE/BE                execute operand selects: 00 regfile, 01 W result, 10 M ALU result
//   o_ForwardAD/BD                branch comparator operand from the M ALU result
//   o_StallF/D, o_FlushD/E        fetch/decode hold and decode/execute clear
module ctrl_hazard_pipe (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_RegWriteD,
  input  logic       i_MemWriteD,
  input  logic       i_ALUSrcD,
  input  logic       i_LoadD,
  input  logic       i_BranchD,
  input  logic       i_JumpRD,
  input  logic       i_PCSrcD,
  input  logic [1:0] i_MemtoRegD,
  input  logic [2:0] i_ALUControlD,
  input  logic [1:0] i_RegDstD,
  input  logic [4:0] i_RsD,
  input  logic [4:0] i_RtD,
  input  logic [4:0] i_RdD,
  input  logic       i_MemStall,
  output logic       o_RegWriteE,
  output logic       o_RegWriteM,
  output logic       o_RegWriteW,
  output logic [1:0] o_MemtoRegE,
  output logic [1:0] o_MemtoRegM,
  output logic [1:0] o_MemtoRegW,
  output logic       o_MemWriteE,
  output logic       o_MemWriteM,
  output logic [2:0] o_ALUControlE,
  output logic       o_ALUSrcE,
  output logic [4:0] o_WriteRegE,
  output logic [4:0] o_WriteRegM,
  output logic [4:0] o_WriteRegW,
  output logic [4:0] o_RsE,
  output logic [4:0] o_RtE,
  output logic [1:0] o_ForwardAE,
  output logic [1:0] o_ForwardBE,
  output logic       o_ForwardAD,
  output logic       o_ForwardBD,
  output logic       o_StallF,
  output logic       o_StallD,
  output logic       o_FlushD,
  output logic       o_FlushE
);

  // Stage register contents. An all-zero value of each is a bubble.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] memto_reg;
    logic       mem_write;
    logic [2:0] alu_ctrl;
    logic       alu_src;
    logic       load;
    logic [4:0] write_reg;
    logic [4:0] rs;
    logic [4:0] rt;
  } e_stage_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] memto_reg;
    logic       mem_write;
    logic       load;
    logic [4:0] write_reg;
  } m_stage_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] memto_reg;
    logic [4:0] write_reg;
  } w_stage_t;

  e_stage_t e_q, e_d, e_cap;
  m_stage_t m_q, m_d;
  w_stage_t w_q, w_d;

  logic [4:0] write_reg_dec;
  logic       br_uses_rs;
  logic       br_uses_rt;
  logic       e_br_hit;
  logic       m_br_hit;
  logic       lw_stall;
  logic       br_stall;
  logic       hz_stall;

  // Operand-A/B select for the execute stage. M wins over W because it is the younger result.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input m_stage_t m,
                                         input w_stage_t w);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != 5'd0 && m.reg_write && m.write_reg == src) begin
      sel = 2'b10;
    end else if (src != 5'd0 && w.reg_write && w.write_reg == src) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // Destination resolved once at D->E capture; RegDst 11 maps to $0, which never matches.
  always_comb begin
    case (i_RegDstD)
      2'b00:   write_reg_dec = i_RtD;
      2'b01:   write_reg_dec = i_RdD;
      2'b10:   write_reg_dec = 5'd31;
      default: write_reg_dec = 5'd0;
    endcase
  end

  always_comb begin
    e_cap           = '0;
    e_cap.reg_write = i_RegWriteD;
    e_cap.memto_reg = i_MemtoRegD;
    e_cap.mem_write = i_MemWriteD;
    e_cap.alu_ctrl  = i_ALUControlD;
    e_cap.alu_src   = i_ALUSrcD;
    e_cap.load      = i_LoadD;
    e_cap.write_reg = write_reg_dec;
    e_cap.rs        = i_RsD;
    e_cap.rt        = i_RtD;
  end

  // Hazard detection. A jr only reads rs; a branch compares rs and rt.
  always_comb begin
    br_uses_rs = i_BranchD | i_JumpRD;
    br_uses_rt = i_BranchD;

    lw_stall = e_q.load && (e_q.rt != 5'd0) &&
               ((e_q.rt == i_RsD) || (e_q.rt == i_RtD));

    // ALU producer in E: its result is not ready for the D-stage comparator yet.
    e_br_hit = e_q.reg_write && (e_q.write_reg != 5'd0) &&
               ((br_uses_rs && e_q.write_reg == i_RsD) ||
                (br_uses_rt && e_q.write_reg == i_RtD));

    // Load producer in M: data only arrives at W, so a second stall cycle is needed.
    m_br_hit = m_q.load && (m_q.write_reg != 5'd0) &&
               ((br_uses_rs && m_q.write_reg == i_RsD) ||
                (br_uses_rt && m_q.write_reg == i_RtD));

    br_stall = e_br_hit | m_br_hit;
    hz_stall = lw_stall | br_stall;
  end

  // Stage advance: freeze holds everything, a hazard stall slips a bubble into E.
  always_comb begin
    e_d = e_q;
    m_d = m_q;
    w_d = w_q;
    if (!i_MemStall) begin
      w_d.reg_write = m_q.reg_write;
      w_d.memto_reg = m_q.memto_reg;
      w_d.write_reg = m_q.write_reg;

      m_d.reg_write = e_q.reg_write;
      m_d.memto_reg = e_q.memto_reg;
      m_d.mem_write = e_q.mem_write;
      m_d.load      = e_q.load;
      m_d.write_reg = e_q.write_reg;

      if (hz_stall) begin
        e_d = '0;
      end else begin
        e_d = e_cap;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  // Stall/flush priority: freeze, then hazard stall, then normal flow.
  // Held at zero while reset is asserted so the core sees a quiet control bundle.
  always_comb begin
    o_StallF = 1'b0;
    o_StallD = 1'b0;
    o_FlushD = 1'b0;
    o_FlushE = 1'b0;
    if (i_rst) begin
      o_StallF = 1'b0;
    end else if (i_MemStall) begin
      o_StallF = 1'b1;
      o_StallD = 1'b1;
    end else if (hz_stall) begin
      // A redirect from a stalled branch is dropped; it re-resolves next cycle.
      o_StallF = 1'b1;
      o_StallD = 1'b1;
      o_FlushE = 1'b1;
    end else begin
      o_FlushD = i_PCSrcD;
    end
  end

  always_comb begin
    o_ForwardAE = 2'b00;
    o_ForwardBE = 2'b00;
    o_ForwardAD = 1'b0;
    o_ForwardBD = 1'b0;
    if (!i_rst) begin
      o_ForwardAE = fwd_sel(e_q.rs, m_q, w_q);
      o_ForwardBE = fwd_sel(e_q.rt, m_q, w_q);
      o_ForwardAD = (i_RsD != 5'd0) && m_q.reg_write && (m_q.write_reg == i_RsD);
      o_ForwardBD = (i_RtD != 5'd0) && m_q.reg_write && (m_q.write_reg == i_RtD);
    end
  end

  assign o_RegWriteE   = e_q.reg_write;
  assign o_MemtoRegE   = e_q.memto_reg;
  assign o_MemWriteE   = e_q.mem_write;
  assign o_ALUControlE = e_q.alu_ctrl;
  assign o_ALUSrcE     = e_q.alu_src;
  assign o_WriteRegE   = e_q.write_reg;
  assign o_RsE         = e_q.rs;
  assign o_RtE         = e_q.rt;

  assign o_RegWriteM   = m_q.reg_write;
  assign o_MemtoRegM   = m_q.memto_reg;
  assign o_MemWriteM   = m_q.mem_write;
  assign o_WriteRegM   = m_q.write_reg;

  assign o_RegWriteW   = w_q.reg_write;
  assign o_MemtoRegW   = w_q.memto_reg;
  assign o_WriteRegW   = w_q.write_reg;

endmodule

// File: tb/tb_ctrl_hazard_pipe.sv
// Self-checking bench for ctrl_hazard_pipe: a reference model tracks whole instructions as they
// move through E/M/W and predicts every output each cycle; a monitor compares at the falling edge.
module tb_ctrl_hazard_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_RegWriteD, i_MemWriteD, i_ALUSrcD, i_LoadD, i_BranchD, i_JumpRD, i_PCSrcD;
  logic [1:0] i_MemtoRegD, i_RegDstD;
  logic [2:0] i_ALUControlD;
  logic [4:0] i_RsD, i_RtD, i_RdD;
  logic       i_MemStall;
  logic       o_RegWriteE, o_RegWriteM, o_RegWriteW;
  logic [1:0] o_MemtoRegE, o_MemtoRegM, o_MemtoRegW;
  logic       o_MemWriteE, o_MemWriteM;
  logic [2:0] o_ALUControlE;
  logic       o_ALUSrcE;
  logic [4:0] o_WriteRegE, o_WriteRegM, o_WriteRegW, o_RsE, o_RtE;
  logic [1:0] o_ForwardAE, o_ForwardBE;
  logic       o_ForwardAD, o_ForwardBD, o_StallF, o_StallD, o_FlushD, o_FlushE;

  always #5 clk = ~clk;

  ctrl_hazard_pipe dut (
    .i_clk(clk), .i_rst(rst),
    .i_RegWriteD(i_RegWriteD), .i_MemWriteD(i_MemWriteD), .i_ALUSrcD(i_ALUSrcD),
    .i_LoadD(i_LoadD), .i_BranchD(i_BranchD), .i_JumpRD(i_JumpRD), .i_PCSrcD(i_PCSrcD),
    .i_MemtoRegD(i_MemtoRegD), .i_ALUControlD(i_ALUControlD), .i_RegDstD(i_RegDstD),
    .i_RsD(i_RsD), .i_RtD(i_RtD), .i_RdD(i_RdD), .i_MemStall(i_MemStall),
    .o_RegWriteE(o_RegWriteE), .o_RegWriteM(o_RegWriteM), .o_RegWriteW(o_RegWriteW),
    .o_MemtoRegE(o_MemtoRegE), .o_MemtoRegM(o_MemtoRegM), .o_MemtoRegW(o_MemtoRegW),
    .o_MemWriteE(o_MemWriteE), .o_MemWriteM(o_MemWriteM), .o_ALUControlE(o_ALUControlE),
    .o_ALUSrcE(o_ALUSrcE), .o_WriteRegE(o_WriteRegE), .o_WriteRegM(o_WriteRegM),
    .o_WriteRegW(o_WriteRegW), .o_RsE(o_RsE), .o_RtE(o_RtE),
    .o_ForwardAE(o_ForwardAE), .o_ForwardBE(o_ForwardBE),
    .o_ForwardAD(o_ForwardAD), .o_ForwardBD(o_ForwardBD),
    .o_StallF(o_StallF), .o_StallD(o_StallD), .o_FlushD(o_FlushD), .o_FlushE(o_FlushE)
  );

  // One decoded instruction as the control unit presents it.
  typedef struct packed {
    logic       rw, mw, alusrc, ld, br, jr, pcsrc;
    logic [1:0] m2r;
    logic [2:0] aluc;
    logic [1:0] rdst;
    logic [4:0] rs, rt, rd;
  } ins_t;

  // ctl = {StallF, StallD, FlushD, FlushE}
  typedef struct packed {
    logic [39:0] pipe;
    logic [5:0]  fwd;
    logic [3:0]  ctl;
  } exp_t;

  typedef struct {
    string nm;
    int    act;
    int    exp;
  } cnt_chk_t;

  exp_t     exp_q[$];
  cnt_chk_t chk_q[$];
  ins_t     prog[$];
  ins_t     st[3];          // instructions currently in E, M, W
  ins_t     cur_d;
  bit       hold_d, flush_next, rand_mode;
  int       n_cmp = 0, n_bad = 0, cnt_stall = 0, cnt_flushd = 0;

  // ---------------- reference model ----------------
  function automatic logic [4:0] dest(input ins_t x);
    case (x.rdst)
      2'b00:   return x.rt;
      2'b01:   return x.rd;
      2'b10:   return 5'd31;
      default: return 5'd0;
    endcase
  endfunction

  function automatic bit writes(input ins_t x, input logic [4:0] r);
    return x.rw && r != 5'd0 && dest(x) == r;
  endfunction

  function automatic bit br_reads(input ins_t d, input logic [4:0] r);
    return r != 5'd0 && (((d.br || d.jr) && d.rs == r) || (d.br && d.rt == r));
  endfunction

  function automatic logic [1:0] fwd_e(input logic [4:0] src);
    if (writes(st[1], src)) return 2'b10;
    if (writes(st[2], src)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t model_out(input ins_t d, input bit rst_v, input bit ms_v,
                                     output bit hz);
    exp_t e;
    bit   lw, brs;
    lw  = st[0].ld && st[0].rt != 5'd0 && (st[0].rt == d.rs || st[0].rt == d.rt);
    brs = (st[0].rw && br_reads(d, dest(st[0]))) || (st[1].ld && br_reads(d, dest(st[1])));
    hz  = lw || brs;
    e.pipe = {st[0].rw, st[0].m2r, st[0].mw, st[0].aluc, st[0].alusrc, dest(st[0]),
              st[0].rs, st[0].rt, st[1].rw, st[1].m2r, st[1].mw, dest(st[1]),
              st[2].rw, st[2].m2r, dest(st[2])};
    if (rst_v) begin
      e.fwd = '0;
      e.ctl = '0;
    end else begin
      e.fwd = {fwd_e(st[0].rs), fwd_e(st[0].rt), writes(st[1], d.rs), writes(st[1], d.rt)};
      if (ms_v)    e.ctl = 4'b1100;
      else if (hz) e.ctl = 4'b1101;
      else         e.ctl = {2'b00, d.pcsrc, 1'b0};
    end
    return e;
  endfunction

  // ---------------- instruction constructors ----------------
  function automatic ins_t mk_alu(input int rd, input int rs, input int rt);
    ins_t x = '0;
    x.rw = 1; x.rdst = 2'b01; x.aluc = 3'b010;
    x.rd = 5'(rd); x.rs = 5'(rs); x.rt = 5'(rt);
    return x;
  endfunction

  function automatic ins_t mk_addi(input int rt, input int rs);
    ins_t x = '0;
    x.rw = 1; x.alusrc = 1; x.aluc = 3'b010; x.rs = 5'(rs); x.rt = 5'(rt);
    return x;
  endfunction

  function automatic ins_t mk_lw(input int rt, input int rs);
    ins_t x = '0;
    x.rw = 1; x.ld = 1; x.m2r = 2'b01; x.alusrc = 1; x.aluc = 3'b010;
    x.rs = 5'(rs); x.rt = 5'(rt);
    return x;
  endfunction

  function automatic ins_t mk_sw(input int rt, input int rs);
    ins_t x = '0;
    x.mw = 1; x.alusrc = 1; x.aluc = 3'b010; x.rs = 5'(rs); x.rt = 5'(rt);
    return x;
  endfunction

  function automatic ins_t mk_beq(input int rs, input int rt, input bit taken);
    ins_t x = '0;
    x.br = 1; x.pcsrc = taken; x.aluc = 3'b110; x.rs = 5'(rs); x.rt = 5'(rt);
    return x;
  endfunction

  function automatic ins_t mk_jr(input int rs);
    ins_t x = '0;
    x.jr = 1; x.pcsrc = 1; x.rs = 5'(rs);
    return x;
  endfunction

  function automatic ins_t mk_jal();
    ins_t x = '0;
    x.rw = 1; x.rdst = 2'b10; x.m2r = 2'b10;
    return x;
  endfunction

  function automatic ins_t rand_ins();
    ins_t        x;
    logic [31:0] r;
    int          a, b, c;
    a = $urandom_range(0, 7); b = $urandom_range(0, 7); c = $urandom_range(0, 7);
    case ($urandom_range(0, 9))
      0, 1:    x = mk_alu(a, b, c);
      2:       x = mk_addi(a, b);
      3, 4:    x = mk_lw(a, b);
      5:       x = mk_sw(a, b);
      6:       x = mk_beq(a, b, 1'($urandom_range(0, 1)));
      7:       x = mk_jr($urandom_range(0, 1) == 1 ? 31 : a);
      8:       x = mk_jal();
      default: begin
        r = $urandom;
        x = r[28:0];
        x.rs = 5'(a); x.rt = 5'(b); x.rd = 5'(c);
      end
    endcase
    return x;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input ins_t x);
    i_RegWriteD = x.rw; i_MemWriteD = x.mw; i_ALUSrcD = x.alusrc; i_LoadD = x.ld;
    i_BranchD = x.br; i_JumpRD = x.jr; i_PCSrcD = x.pcsrc; i_MemtoRegD = x.m2r;
    i_ALUControlD = x.aluc; i_RegDstD = x.rdst; i_RsD = x.rs; i_RtD = x.rt; i_RdD = x.rd;
  endtask

  // Called just after a rising edge: present one cycle of inputs, predict, then advance the model.
  task automatic step(input bit rst_v, input bit ms_v);
    exp_t e;
    bit   hz;
    if (!hold_d) begin
      if (flush_next)            cur_d = '0;
      else if (prog.size() != 0) cur_d = prog.pop_front();
      else if (rand_mode)        cur_d = rand_ins();
      else                       cur_d = '0;
    end
    rst = rst_v;
    i_MemStall = ms_v;
    drive(cur_d);
    if (rst_v) for (int i = 0; i < 3; i++) st[i] = '0;
    e = model_out(cur_d, rst_v, ms_v, hz);
    exp_q.push_back(e);
    hold_d = e.ctl[2];
    flush_next = e.ctl[1];
    @(posedge clk);
    #1;
    if (rst_v) begin
      for (int i = 0; i < 3; i++) st[i] = '0;
    end else if (!ms_v) begin
      st[2] = st[1];
      st[1] = st[0];
      st[0] = hz ? '0 : cur_d;
    end
  endtask

  task automatic check_counts(input string nm, input int base_s, input int base_f,
                              input int exp_s, input int exp_f);
    cnt_chk_t c;
    c.nm = {nm, "_stall_cycles"}; c.act = cnt_stall - base_s;  c.exp = exp_s;
    chk_q.push_back(c);
    c.nm = {nm, "_flushd_cycles"}; c.act = cnt_flushd - base_f; c.exp = exp_f;
    chk_q.push_back(c);
  endtask

  task automatic run_seq(input string nm, input int exp_s, input int exp_f);
    int bs, bf;
    bs = cnt_stall;
    bf = cnt_flushd;
    repeat (8) step(1'b0, 1'b0);
    check_counts(nm, bs, bf, exp_s, exp_f);
  endtask

  // ---------------- monitor ----------------
  exp_t        mon_e;
  cnt_chk_t    mon_c;
  logic [39:0] act_pipe;
  logic [5:0]  act_fwd;
  logic [3:0]  act_ctl;

  always @(negedge clk) begin
    if (o_StallF) cnt_stall++;
    if (o_FlushD) cnt_flushd++;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      act_pipe = {o_RegWriteE, o_MemtoRegE, o_MemWriteE, o_ALUControlE, o_ALUSrcE, o_WriteRegE,
                  o_RsE, o_RtE, o_RegWriteM, o_MemtoRegM, o_MemWriteM, o_WriteRegM,
                  o_RegWriteW, o_MemtoRegW, o_WriteRegW};
      act_fwd = {o_ForwardAE, o_ForwardBE, o_ForwardAD, o_ForwardBD};
      act_ctl = {o_StallF, o_StallD, o_FlushD, o_FlushE};
      n_cmp += 3;
      if (act_pipe !== mon_e.pipe) begin
        n_bad++;
        $display("FAIL stage_regs @%0t: got %h required %h", $time, act_pipe, mon_e.pipe);
      end
      if (act_fwd !== mon_e.fwd) begin
        n_bad++;
        $display("FAIL forward_sel @%0t: got %b required %b", $time, act_fwd, mon_e.fwd);
      end
      if (act_ctl !== mon_e.ctl) begin
        n_bad++;
        $display("FAIL stall_flush @%0t: got %b required %b", $time, act_ctl, mon_e.ctl);
      end
    end
    while (chk_q.size() != 0) begin
      mon_c = chk_q.pop_front();
      n_cmp++;
      if (mon_c.act != mon_c.exp) begin
        n_bad++;
        $display("FAIL %s: got %0d required %0d", mon_c.nm, mon_c.act, mon_c.exp);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int bs, bf;
    rst = 1'b1;
    i_MemStall = 1'b0;
    cur_d = '0;
    drive(cur_d);
    hold_d = 0; flush_next = 0; rand_mode = 0;
    for (int i = 0; i < 3; i++) st[i] = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with garbage on D and a freeze request: everything must read 0.
    prog.push_back(mk_lw(3, 1));
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);

    // Random traffic with occasional freezes and resets.
    rand_mode = 1;
    repeat (600) step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0);
    rand_mode = 0;

    // Reset mid-stream: whatever is in flight is discarded.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    prog.push_back(mk_lw(8, 9));
    prog.push_back(mk_alu(10, 8, 11));
    run_seq("lw_use", 1, 0);

    prog.push_back(mk_alu(3, 1, 2));
    prog.push_back(mk_alu(4, 3, 3));
    prog.push_back(mk_alu(3, 1, 2));
    prog.push_back(mk_alu(7, 6, 6));
    prog.push_back(mk_alu(4, 3, 3));
    run_seq("ex_forward", 0, 0);

    prog.push_back(mk_alu(5, 1, 2));
    prog.push_back(mk_beq(5, 6, 1'b0));
    run_seq("alu_beq", 1, 0);

    prog.push_back(mk_lw(5, 1));
    prog.push_back(mk_beq(5, 6, 1'b0));
    run_seq("lw_beq", 2, 0);

    prog.push_back(mk_addi(0, 0));
    prog.push_back(mk_alu(4, 0, 0));
    prog.push_back(mk_lw(0, 1));
    prog.push_back(mk_beq(0, 0, 1'b0));
    run_seq("reg_zero", 0, 0);

    prog.push_back(mk_alu(9, 1, 2));
    prog.push_back(mk_jr(31));
    run_seq("jr_plain", 0, 1);

    prog.push_back(mk_jal());
    prog.push_back(mk_jr(31));
    run_seq("jal_jr", 1, 1);

    // Freeze for three cycles while a store sits in M.
    bs = cnt_stall;
    bf = cnt_flushd;
    prog.push_back(mk_sw(2, 3));
    repeat (3) step(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0);
    check_counts("mem_freeze", bs, bf, 3, 0);

    // Longer random run.
    rand_mode = 1;
    repeat (1500) step($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0);
    rand_mode = 0;
    repeat (4) step(1'b0, 1'b0);

    for (int i = 0; i < 10 && (exp_q.size() != 0 || chk_q.size() != 0); i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations never consumed, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
